demux_8: RTL and testbench

//   Registered 1-to-8 demultiplexer: the write-side counterpart of mux_8.

---
 rtl/demux_8_pkg.sv | 27 ++
 rtl/demux_8_if.sv | 40 ++++
 rtl/demux_8_slot.sv | 45 ++++
 rtl/demux_8.sv | 72 +++++++
 tb/tb_demux_8.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/demux_8_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : demux_8_pkg
//  Description : Shared sizes, types and helpers for the demux_8 block.
//  Revision    : 1.0 - initial release
// ============================================================================
package demux_8_pkg;

    localparam int N_DEMUX_OUT = 8;
    localparam int DEMUX_SEL_W = 3;
    localparam int DEMUX_CNT_W = 4;

    typedef logic [DEMUX_SEL_W-1:0] sel_t;
    typedef logic [N_DEMUX_OUT-1:0] slot_mask_t;
    typedef logic [DEMUX_CNT_W-1:0] cnt_t;

    function automatic cnt_t popcount(input slot_mask_t i_mask);
        cnt_t w_cnt;
        w_cnt = '0;
        for (int i = 0; i < N_DEMUX_OUT; i++) begin
            w_cnt = w_cnt + cnt_t'(i_mask[i]);
        end
        return w_cnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/demux_8_if.sv
`default_nettype none
// ============================================================================
//  Module      : demux_8_if
//  Description : Input stream and eight output slots of the demux_8 block.
//  Revision    : 1.0 - initial release
// ============================================================================
interface demux_8_if
    import demux_8_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    sel_t             sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] o_0;
    logic [WIDTH-1:0] o_1;
    logic [WIDTH-1:0] o_2;
    logic [WIDTH-1:0] o_3;
    logic [WIDTH-1:0] o_4;
    logic [WIDTH-1:0] o_5;
    logic [WIDTH-1:0] o_6;
    logic [WIDTH-1:0] o_7;
    slot_mask_t       out_valid;
    slot_mask_t       out_ready;
    cnt_t             occupancy;

    modport master (
        output in_data, sel, in_valid, out_ready,
        input  in_ready, o_0, o_1, o_2, o_3, o_4, o_5, o_6, o_7,
        input  out_valid, occupancy
    );

    modport slave (
        input  in_data, sel, in_valid, out_ready,
        output in_ready, o_0, o_1, o_2, o_3, o_4, o_5, o_6, o_7,
        output out_valid, occupancy
    );
endinterface
`default_nettype wire

// File: rtl/demux_8_slot.sv
`default_nettype none
// ============================================================================
//  Module      : demux_8_slot
//  Description : One-entry output buffer (data register + valid flag).
//  Revision    : 1.0 - initial release
// ============================================================================
module demux_8_slot #(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_wr_en,
    input  wire logic [WIDTH-1:0] i_wr_data,
    input  wire logic             i_rd_ready,
    output logic                  o_valid,
    output logic [WIDTH-1:0]      o_data,
    output logic                  o_can_accept
);
    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // A write in the same cycle as a drain wins, so the slot stays full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
        end else if (i_wr_en) begin
            r_valid <= 1'b1;
        end else if (i_rd_ready) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
        end else if (i_wr_en) begin
            r_data <= i_wr_data;
        end
    end

    assign o_valid      = r_valid;
    assign o_data       = r_data;
    assign o_can_accept = ~r_valid | i_rd_ready;
endmodule
`default_nettype wire

// File: rtl/demux_8.sv
`default_nettype none
// ============================================================================
//  Module      : demux_8
//  Description : Registered 1-to-8 demultiplexer with per-slot valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module demux_8
    import demux_8_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  wire logic clk,
    input  wire logic rst,
    demux_8_if.slave  bus
);
    logic [WIDTH-1:0] w_data [N_DEMUX_OUT];
    slot_mask_t       w_valid;
    slot_mask_t       w_can_accept;
    slot_mask_t       w_wr_en;
    slot_mask_t       w_drain;
    logic             w_fill;
    cnt_t             w_drain_cnt;
    cnt_t             r_occ;

    // sel only reaches state through in_valid, so an unknown sel while idle is harmless.
    always_comb begin
        w_wr_en = '0;
        for (int k = 0; k < N_DEMUX_OUT; k++) begin
            w_wr_en[k] = bus.in_valid & w_can_accept[k] & (bus.sel == sel_t'(k));
        end
    end

    assign bus.in_ready = w_can_accept[bus.sel];
    assign w_drain      = w_valid & bus.out_ready;
    assign w_fill       = |(w_wr_en & ~w_valid);
    assign w_drain_cnt  = popcount(w_drain & ~w_wr_en);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ <= '0;
        end else begin
            r_occ <= r_occ + cnt_t'(w_fill) - w_drain_cnt;
        end
    end

    for (genvar k = 0; k < N_DEMUX_OUT; k++) begin : g_slot
        demux_8_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk          (clk),
            .rst          (rst),
            .i_wr_en      (w_wr_en[k]),
            .i_wr_data    (bus.in_data),
            .i_rd_ready   (bus.out_ready[k]),
            .o_valid      (w_valid[k]),
            .o_data       (w_data[k]),
            .o_can_accept (w_can_accept[k])
        );
    end

    assign bus.out_valid = w_valid;
    assign bus.occupancy = r_occ;
    assign bus.o_0       = w_data[0];
    assign bus.o_1       = w_data[1];
    assign bus.o_2       = w_data[2];
    assign bus.o_3       = w_data[3];
    assign bus.o_4       = w_data[4];
    assign bus.o_5       = w_data[5];
    assign bus.o_6       = w_data[6];
    assign bus.o_7       = w_data[7];
endmodule
`default_nettype wire

// File: tb/tb_demux_8.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux_8
//  Description : Self-checking bench for demux_8 against a per-slot model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_8;
    import demux_8_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    demux_8_if #(.WIDTH(8)) bus ();
    demux_8 #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [7:0] obs [8];
    assign obs[0] = bus.o_0;
    assign obs[1] = bus.o_1;
    assign obs[2] = bus.o_2;
    assign obs[3] = bus.o_3;
    assign obs[4] = bus.o_4;
    assign obs[5] = bus.o_5;
    assign obs[6] = bus.o_6;
    assign obs[7] = bus.o_7;

    int checks   = 0;
    int failures = 0;
    int n_acc    = 0;
    int n_del    = 0;

    // Each slot is a queue of depth one: a held flag and the word it holds.
    bit         mvalid [8];
    logic [7:0] mdata  [8];

    typedef struct {
        logic [2:0] sel;
        logic [7:0] data;
        logic [7:0] exp_valid;
        logic [3:0] exp_occ;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int mocc();
        int c = 0;
        for (int i = 0; i < 8; i++) c += int'(mvalid[i]);
        return c;
    endfunction

    function automatic logic [7:0] mmask();
        logic [7:0] m;
        for (int i = 0; i < 8; i++) m[i] = mvalid[i];
        return m;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            mvalid[i] = 1'b0;
            mdata[i]  = 8'h00;
        end
    endtask

    // One clock: drive, check readiness and delivered words, advance model, check state.
    task automatic cycle(input bit v, input logic [2:0] s, input logic [7:0] d, input logic [7:0] ord);
        bit rdy;
        bus.in_valid  = v;
        bus.sel       = s;
        bus.in_data   = d;
        bus.out_ready = ord;
        #1;
        rdy = !mvalid[s] || ord[s];
        chk("in_ready", 32'(bus.in_ready), 32'(rdy));
        for (int k = 0; k < 8; k++) begin
            if (mvalid[k] && ord[k]) begin
                chk("drain_data", 32'(obs[k]), 32'(mdata[k]));
                n_del++;
                mvalid[k] = 1'b0;
            end
        end
        if (v && rdy) begin
            mvalid[s] = 1'b1;
            mdata[s]  = d;
            n_acc++;
        end
        @(posedge clk);
        #1;
        chk("out_valid", 32'(bus.out_valid), 32'(mmask()));
        chk("occupancy", 32'(bus.occupancy), 32'(mocc()));
        for (int k = 0; k < 8; k++) begin
            if (mvalid[k]) chk("slot_data", 32'(obs[k]), 32'(mdata[k]));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t       tbl [8];
        logic [7:0] sweep_data [8];
        logic [7:0] onehot;

        sweep_data = '{8'd51, 8'd5, 8'd17, 8'd44, 8'd87, 8'd32, 8'd98, 8'd12};
        for (int i = 0; i < 8; i++) begin
            onehot        = 8'h00;
            onehot[i]     = 1'b1;
            tbl[i].sel       = 3'(i);
            tbl[i].data      = sweep_data[i];
            tbl[i].exp_valid = onehot;
            tbl[i].exp_occ   = 4'd1;
        end

        // Power-on reset
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.sel       = 3'd0;
        bus.in_data   = 8'h00;
        bus.out_ready = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'h00);
        chk("rst_occupancy", 32'(bus.occupancy), 32'd0);
        rst = 1'b0;

        // Sweep every slot with all consumers ready
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, tbl[i].sel, tbl[i].data, 8'hFF);
            chk("sweep_valid", 32'(bus.out_valid), 32'(tbl[i].exp_valid));
            chk("sweep_occ", 32'(bus.occupancy), 32'(tbl[i].exp_occ));
            chk("sweep_data", 32'(obs[tbl[i].sel]), 32'(tbl[i].data));
        end
        cycle(1'b0, 3'd0, 8'h00, 8'hFF);

        // Backpressure on slot 3
        cycle(1'b1, 3'd3, 8'd44, 8'h00);
        cycle(1'b1, 3'd3, 8'd87, 8'h00);
        chk("bp_ready_low", 32'(bus.in_ready), 32'd0);
        chk("bp_hold", 32'(obs[3]), 32'd44);
        chk("bp_occ", 32'(bus.occupancy), 32'd1);
        cycle(1'b1, 3'd3, 8'd87, 8'h08);
        chk("bp_accept", 32'(obs[3]), 32'd87);
        cycle(1'b0, 3'd0, 8'h00, 8'hFF);

        // Same-slot write and drain
        cycle(1'b1, 3'd5, 8'd32, 8'h00);
        cycle(1'b1, 3'd5, 8'd98, 8'h20);
        chk("wd_data", 32'(obs[5]), 32'd98);
        chk("wd_valid", 32'(bus.out_valid[5]), 32'd1);
        chk("wd_occ", 32'(bus.occupancy), 32'd1);
        cycle(1'b0, 3'd0, 8'h00, 8'hFF);

        // Fill all slots, then drain them together
        for (int k = 0; k < 8; k++) cycle(1'b1, 3'(k), 8'(k * 7 + 3), 8'h00);
        chk("full_occ", 32'(bus.occupancy), 32'd8);
        bus.in_valid = 1'b0;
        for (int s = 0; s < 8; s++) begin
            bus.sel = 3'(s);
            #1;
            chk("full_ready", 32'(bus.in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        cycle(1'b0, 3'd0, 8'h00, 8'hFF);
        chk("drain_all_occ", 32'(bus.occupancy), 32'd0);
        chk("drain_all_valid", 32'(bus.out_valid), 32'h00);

        // Asynchronous reset with three slots full and a word in flight
        cycle(1'b1, 3'd0, 8'h11, 8'h00);
        cycle(1'b1, 3'd4, 8'h44, 8'h00);
        cycle(1'b1, 3'd6, 8'h66, 8'h00);
        bus.in_valid = 1'b1;
        bus.sel      = 3'd2;
        bus.in_data  = 8'h22;
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'h00);
        chk("mid_rst_occ", 32'(bus.occupancy), 32'd0);
        for (int k = 0; k < 8; k++) chk("mid_rst_data", 32'(obs[k]), 32'h00);
        model_reset();
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_valid", 32'(bus.out_valid), 32'h00);
        chk("post_rst_occ", 32'(bus.occupancy), 32'd0);

        // Random traffic against the model
        n_acc = 0;
        n_del = 0;
        for (int n = 0; n < 10000; n++) begin
            cycle(1'($urandom_range(0, 1)), 3'($urandom), 8'($urandom), 8'($urandom));
        end
        cycle(1'b0, 3'd0, 8'h00, 8'hFF);
        chk("no_loss", 32'(n_del), 32'(n_acc));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
